// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: fetch state encoding plus reset-PC and increment defaults shared with pc
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, IDLE = 2'd1, REQ = 2'd2} state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int DEF_INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: one-entry instruction buffer with flush, consume and delivered counter
module fetch_out_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_fill,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [DATA_WIDTH-1:0]  i_pc,
  input  logic                   i_flush,
  input  logic                   i_stall,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_instr,
  output logic [DATA_WIDTH-1:0]  o_pc,
  output logic [COUNT_WIDTH-1:0] o_count
);
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_instr, r_pc;
  logic [COUNT_WIDTH-1:0] r_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_instr <= i_data;
      r_pc    <= i_pc;
    end else if (r_valid && !i_stall) begin
      r_valid <= 1'b0;
      r_count <= r_count + 1'b1;
    end
  end
  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_count = r_count;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC generator and req/ack fetch sequencer driving the pc register load port
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(DEF_RESET_PC),
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_PC,
  output logic                   o_Load,
  output logic [DATA_WIDTH-1:0]  o_PC,
  output logic                   o_IMem_Req,
  output logic [DATA_WIDTH-1:0]  o_IMem_Addr,
  input  logic                   i_IMem_Ack,
  input  logic [DATA_WIDTH-1:0]  i_IMem_Data,
  input  logic                   i_Redirect,
  input  logic [DATA_WIDTH-1:0]  i_Redirect_PC,
  input  logic                   i_Stall,
  output logic                   o_Instr_Valid,
  output logic [DATA_WIDTH-1:0]  o_Instr,
  output logic [DATA_WIDTH-1:0]  o_Instr_PC,
  output logic [COUNT_WIDTH-1:0] o_Fetch_Count
);
  state_t                r_state, w_next;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_pend_pc;
  logic                  w_load, w_fill, w_pend_set, w_pend_clr;
  logic [DATA_WIDTH-1:0] w_pc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= BOOT;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_state <= w_next;
      if (w_pend_set) begin
        r_pend    <= 1'b1;
        r_pend_pc <= i_Redirect_PC;
      end else if (w_pend_clr) begin
        r_pend <= 1'b0;
      end
    end
  end
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_pc       = i_PC;
    w_fill     = 1'b0;
    w_pend_set = 1'b0;
    w_pend_clr = 1'b0;
    if (r_state == BOOT) begin
      w_load = 1'b1;
      w_pc   = i_Redirect ? i_Redirect_PC : RESET_PC;
      w_next = REQ;
    end else if (r_state == IDLE) begin
      w_load = i_Redirect;
      w_pc   = i_Redirect ? i_Redirect_PC : i_PC;
      w_next = (i_Redirect || !o_Instr_Valid || !i_Stall) ? REQ : IDLE;
    end else if (i_IMem_Ack) begin
      // a redirect seen during this fetch makes its data stale, so refetch from the target
      w_load     = 1'b1;
      w_pend_clr = 1'b1;
      w_fill     = !i_Redirect && !r_pend;
      w_pc       = i_Redirect ? i_Redirect_PC : r_pend ? r_pend_pc : i_PC + DATA_WIDTH'(INSTR_BYTES);
      w_next     = w_fill ? IDLE : REQ;
    end else begin
      w_pend_set = i_Redirect;
    end
  end
  assign o_Load      = reset && w_load;
  assign o_PC        = reset ? w_pc : RESET_PC;
  assign o_IMem_Req  = reset && (r_state == REQ);
  assign o_IMem_Addr = i_PC;
  fetch_out_buf #(.DATA_WIDTH(DATA_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_fill  (w_fill && reset),
    .i_data  (i_IMem_Data),
    .i_pc    (i_PC),
    .i_flush (i_Redirect),
    .i_stall (i_Stall),
    .o_valid (o_Instr_Valid),
    .o_instr (o_Instr),
    .o_pc    (o_Instr_PC),
    .o_count (o_Fetch_Count)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl with a pc register and a gated zero-wait memory model
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        o_Load, o_IMem_Req, i_IMem_Ack, i_Redirect, i_Stall, o_Instr_Valid;
  logic [31:0] o_PC, o_IMem_Addr, i_IMem_Data, i_Redirect_PC, o_Instr, o_Instr_PC;
  logic [15:0] o_Fetch_Count;
  logic        mem_ok;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'h0;
    else if (o_Load) pc <= o_PC;
  end
  assign i_IMem_Ack  = o_IMem_Req && mem_ok;
  assign i_IMem_Data = ~o_IMem_Addr;
  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .i_PC          (pc),
    .o_Load        (o_Load),
    .o_PC          (o_PC),
    .o_IMem_Req    (o_IMem_Req),
    .o_IMem_Addr   (o_IMem_Addr),
    .i_IMem_Ack    (i_IMem_Ack),
    .i_IMem_Data   (i_IMem_Data),
    .i_Redirect    (i_Redirect),
    .i_Redirect_PC (i_Redirect_PC),
    .i_Stall       (i_Stall),
    .o_Instr_Valid (o_Instr_Valid),
    .o_Instr       (o_Instr),
    .o_Instr_PC    (o_Instr_PC),
    .o_Fetch_Count (o_Fetch_Count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    i_Redirect = 1'b0;
    i_Redirect_PC = 32'h0;
    i_Stall = 1'b0;
    mem_ok = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_load", o_Load, 0);
    check("rst_pc", o_PC, 0);
    check("rst_req", o_IMem_Req, 0);
    check("rst_valid", o_Instr_Valid, 0);
    check("rst_instr", o_Instr, 0);
    check("rst_ipc", o_Instr_PC, 0);
    check("rst_cnt", o_Fetch_Count, 0);
    cyc();
    reset = 1'b1;
    #1;
    check("boot_load", o_Load, 1);
    check("boot_pc", o_PC, 32'h0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("seq_req", o_IMem_Req, 1);
      check("seq_addr", o_IMem_Addr, 4 * i);
      check("seq_load", o_Load, 1);
      check("seq_npc", o_PC, 4 * i + 4);
      check("seq_cnt", o_Fetch_Count, i);
      cyc();
      check("seq_valid", o_Instr_Valid, 1);
      check("seq_ipc", o_Instr_PC, 4 * i);
      check("seq_instr", o_Instr, ~(4 * i));
      check("seq_idle_req", o_IMem_Req, 0);
      if (i == 3) mem_ok = 1'b0;
      cyc();
    end
    check("t1_cnt", o_Fetch_Count, 4);
    check("t1_req", o_IMem_Req, 1);
    check("t1_addr", o_IMem_Addr, 32'h10);
    check("t1_noack_load", o_Load, 0);
    mem_ok = 1'b1;
    #1;
    check("t1_ack_pc", o_PC, 32'h14);
    cyc();
    check("idle_valid", o_Instr_Valid, 1);
    check("idle_ipc", o_Instr_PC, 32'h10);
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'h100;
    mem_ok = 1'b0;
    #1;
    check("rd_idle_load", o_Load, 1);
    check("rd_idle_pc", o_PC, 32'h100);
    cyc();
    i_Redirect = 1'b0;
    #1;
    check("rd_flush", o_Instr_Valid, 0);
    check("rd_flush_cnt", o_Fetch_Count, 4);
    for (int i = 0; i < 3; i++) begin
      check("wait_req", o_IMem_Req, 1);
      check("wait_addr", o_IMem_Addr, 32'h100);
      check("wait_load", o_Load, 0);
      cyc();
    end
    mem_ok = 1'b1;
    i_Stall = 1'b1;
    #1;
    check("wait_ack_load", o_Load, 1);
    check("wait_ack_pc", o_PC, 32'h104);
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("stall_req", o_IMem_Req, 0);
      check("stall_valid", o_Instr_Valid, 1);
      check("stall_instr", o_Instr, ~32'h100);
      check("stall_ipc", o_Instr_PC, 32'h100);
      check("stall_cnt", o_Fetch_Count, 4);
      if (i < 4) cyc();
    end
    i_Stall = 1'b0;
    mem_ok = 1'b0;
    #1;
    check("drain_load", o_Load, 0);
    cyc();
    check("drain_cnt", o_Fetch_Count, 5);
    check("drain_valid", o_Instr_Valid, 0);
    check("drain_req", o_IMem_Req, 1);
    check("drain_addr", o_IMem_Addr, 32'h104);
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'h8000_0000;
    #1;
    check("pend_noload", o_Load, 0);
    cyc();
    i_Redirect = 1'b0;
    #1;
    check("pend_req", o_IMem_Req, 1);
    check("pend_addr", o_IMem_Addr, 32'h104);
    check("pend_load", o_Load, 0);
    cyc();
    mem_ok = 1'b1;
    #1;
    check("pend_ack_load", o_Load, 1);
    check("pend_ack_pc", o_PC, 32'h8000_0000);
    cyc();
    check("pend_next_req", o_IMem_Req, 1);
    check("pend_next_addr", o_IMem_Addr, 32'h8000_0000);
    check("pend_discard", o_Instr_Valid, 0);
    check("pend_cnt", o_Fetch_Count, 5);
    mem_ok = 1'b0;
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'hA000;
    #1;
    check("multi_noload", o_Load, 0);
    cyc();
    i_Redirect_PC = 32'hB000;
    cyc();
    i_Redirect_PC = 32'hC000;
    mem_ok = 1'b1;
    #1;
    check("multi3_load", o_Load, 1);
    check("multi3_pc", o_PC, 32'hC000);
    cyc();
    i_Redirect = 1'b0;
    mem_ok = 1'b0;
    #1;
    check("multi3_addr", o_IMem_Addr, 32'hC000);
    check("multi3_valid", o_Instr_Valid, 0);
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'hA000;
    cyc();
    i_Redirect_PC = 32'hB000;
    cyc();
    i_Redirect = 1'b0;
    mem_ok = 1'b1;
    #1;
    check("multi2_load", o_Load, 1);
    check("multi2_pc", o_PC, 32'hB000);
    cyc();
    check("multi2_addr", o_IMem_Addr, 32'hB000);
    check("multi2_valid", o_Instr_Valid, 0);
    cyc();
    check("b000_valid", o_Instr_Valid, 1);
    check("b000_ipc", o_Instr_PC, 32'hB000);
    check("b000_cnt", o_Fetch_Count, 5);
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'hFFFF_FFFC;
    #1;
    check("top_load", o_Load, 1);
    check("top_pc", o_PC, 32'hFFFF_FFFC);
    cyc();
    i_Redirect = 1'b0;
    #1;
    check("wrap_addr", o_IMem_Addr, 32'hFFFF_FFFC);
    check("wrap_flush", o_Instr_Valid, 0);
    check("wrap_flush_cnt", o_Fetch_Count, 5);
    check("wrap_load", o_Load, 1);
    check("wrap_pc", o_PC, 32'h0);
    cyc();
    check("wrap_ipc", o_Instr_PC, 32'hFFFF_FFFC);
    check("wrap_instr", o_Instr, 32'h3);
    mem_ok = 1'b0;
    cyc();
    check("mid_req", o_IMem_Req, 1);
    check("mid_addr", o_IMem_Addr, 32'h0);
    check("mid_cnt", o_Fetch_Count, 6);
    reset = 1'b0;
    #1;
    check("arst_req", o_IMem_Req, 0);
    check("arst_valid", o_Instr_Valid, 0);
    check("arst_cnt", o_Fetch_Count, 0);
    check("arst_load", o_Load, 0);
    check("arst_pc", o_PC, 32'h0);
    cyc();
    check("arst_hold_load", o_Load, 0);
    check("arst_hold_req", o_IMem_Req, 0);
    reset = 1'b1;
    #1;
    check("reboot_load", o_Load, 1);
    check("reboot_pc", o_PC, 32'h0);
    cyc();
    check("reboot_req", o_IMem_Req, 1);
    check("reboot_addr", o_IMem_Addr, 32'h0);
    check("reboot_noload", o_Load, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
